div_unit: RTL

- Multi-cycle radix-2 restoring divider; the responder side of the execute stage's divide handshake (operands, start, signed flag in; 64-bit result and ready out).
- Serves DIV/DIVU. Result is packed {remainder, quotient}, so the execute stage writes HI = remainder and LO = quotient.
- Execute stage holds start and stalls the pipeline until ready. The divider owns all iteration state.

---
 rtl/div_unit_pkg.sv | 20 ++
 rtl/div_unit_if.sv | 24 ++
 rtl/div_unit_step.sv | 20 ++
 rtl/div_unit.sv | 124 ++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// Shared constants for the execute-stage divide handshake and the divider FSM.
// These values are shared with the execute stage.
package div_unit_pkg;

   typedef enum logic [1:0] {
      FREE    = 2'b00,
      BY_ZERO = 2'b01,
      ON      = 2'b10,
      END     = 2'b11
   } div_state_e;

   localparam logic DIV_START            = 1'b1;
   localparam logic DIV_STOP             = 1'b0;
   localparam logic DIV_RESULT_READY     = 1'b1;
   localparam logic DIV_RESULT_NOT_READY = 1'b0;

   localparam int              WORD_W   = 32;
   localparam logic [WORD_W-1:0] ZEROWORD = '0;

endpackage

// File: rtl/div_unit_if.sv
// Divide request/response handshake between the execute stage (master) and the divider (slave).
interface div_if
   import div_unit_pkg::*;
#(
   parameter int DATA_W = 32
);
   logic                  signed_div_i;
   logic [DATA_W-1:0]     operand_1_i;
   logic [DATA_W-1:0]     operand_2_i;
   logic                  start_i;
   logic                  annul_i;
   logic [2*DATA_W-1:0]   result_o;
   logic                  ready_o;

   modport master (
      output signed_div_i, operand_1_i, operand_2_i, start_i, annul_i,
      input  result_o, ready_o
   );

   modport slave (
      input  signed_div_i, operand_1_i, operand_2_i, start_i, annul_i,
      output result_o, ready_o
   );
endinterface

// File: rtl/div_unit_step.sv
// One radix-2 restoring step: trial-subtract the divisor from the upper half of W,
// keep the difference and shift in a 1 when it fits, otherwise just shift.
module div_step #(
   parameter int DATA_W = 32
) (
   input  logic [2*DATA_W:0] w_in,
   input  logic [DATA_W-1:0] divisor,
   output logic [2*DATA_W:0] w_out
);
   logic [DATA_W:0] diff;

   always_comb begin
      diff = w_in[2*DATA_W:DATA_W] - {1'b0, divisor};
      if (diff[DATA_W]) begin
         w_out = {w_in[2*DATA_W-1:0], 1'b0};
      end else begin
         w_out = {diff[DATA_W-1:0], w_in[DATA_W-1:0], 1'b1};
      end
   end
endmodule

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU; returns {remainder, quotient}.
// The execute stage holds start until ready and drops it for a cycle between requests.
module div_unit
   import div_unit_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CNT_W  = $clog2(DATA_W) + 1
) (
   input  logic clk,
   input  logic rst,
   div_if.slave bus
);

   function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                   input logic is_signed);
      logic signed [DATA_W-1:0] sv;
      sv = v;
      return (is_signed && sv < 0) ? DATA_W'(-sv) : v;
   endfunction

   function automatic logic [DATA_W-1:0] apply_sign(input logic [DATA_W-1:0] mag,
                                                    input logic neg);
      logic signed [DATA_W-1:0] sm;
      sm = mag;
      return neg ? DATA_W'(-sm) : mag;
   endfunction

   div_state_e            state;
   logic [CNT_W-1:0]      cnt;
   logic [2*DATA_W:0]     w;
   logic [2*DATA_W:0]     w_next;
   logic [DATA_W-1:0]     divisor;
   logic                  q_neg;
   logic                  r_neg;
   logic [DATA_W-1:0]     quo_raw;
   logic [DATA_W-1:0]     rem_raw;
   logic                  unused_mid;
   logic [2*DATA_W-1:0]   result;
   logic                  ready;
   logic                  launch;
   logic                  abort;

   assign launch = (bus.start_i == DIV_START) && !bus.annul_i;
   assign abort  = bus.annul_i || (bus.start_i == DIV_STOP);

   div_step #(.DATA_W(DATA_W)) u_step (
      .w_in    (w),
      .divisor (divisor),
      .w_out   (w_next)
   );

   // After the last step the bit between remainder and quotient is a stale shifted-in zero.
   assign {rem_raw, unused_mid, quo_raw} = w_next;

   // Operand datapath: latched on a FREE-state launch, iterated while ON.
   always_ff @(posedge clk) begin
      if (state == FREE && launch) begin
         w       <= {{DATA_W{1'b0}}, magnitude(bus.operand_1_i, bus.signed_div_i), 1'b0};
         divisor <= magnitude(bus.operand_2_i, bus.signed_div_i);
         q_neg   <= bus.signed_div_i & (bus.operand_1_i[DATA_W-1] ^ bus.operand_2_i[DATA_W-1]);
         r_neg   <= bus.signed_div_i & bus.operand_1_i[DATA_W-1];
      end else if (state == ON) begin
         w <= w_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= FREE;
         cnt    <= '0;
         result <= '0;
         ready  <= DIV_RESULT_NOT_READY;
      end else begin
         case (state)
            FREE: begin
               ready  <= DIV_RESULT_NOT_READY;
               result <= '0;
               if (launch) begin
                  cnt <= '0;
                  if (bus.operand_2_i == DATA_W'(ZEROWORD)) begin
                     state <= BY_ZERO;
                  end else begin
                     state <= ON;
                  end
               end
            end
            BY_ZERO: begin
               if (abort) begin
                  state <= FREE;
               end else begin
                  state  <= END;
                  result <= '0;
                  ready  <= DIV_RESULT_READY;
               end
            end
            ON: begin
               if (abort) begin
                  state <= FREE;
                  cnt   <= '0;
               end else if (cnt == CNT_W'(DATA_W - 1)) begin
                  state  <= END;
                  cnt    <= '0;
                  result <= {apply_sign(rem_raw, r_neg), apply_sign(quo_raw, q_neg)};
                  ready  <= DIV_RESULT_READY;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            END: begin
               // Result stays put until the execute stage releases start.
               if (abort) begin
                  state  <= FREE;
                  result <= '0;
                  ready  <= DIV_RESULT_NOT_READY;
               end
            end
         endcase
      end
   end

   assign bus.result_o = result;
   assign bus.ready_o  = ready;

endmodule
